mul_wb_pipe: RTL and testbench

- Downstream stage of the combinational RV32M multiplier. It registers the multiplier result together with its destination register over a configurable pipeline.
- Results drain to the integer writeback port through a skid FIFO that honours writeback backpressure.
- Provides a pending-rd scoreboard mask for issue hazard checks, and a stall output so upstream never overruns the buffer.

---
 rtl/mul_wb_pipe.sv | 169 ++++++++++++++++
 tb/tb_mul_wb_pipe.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mul_wb_pipe.sv
// mul_wb_pipe: registers RV32M multiplier results with their rd over a short
// pipeline, then drains them in order to writeback through a skid FIFO.
// Also exports a pending-rd hazard mask and an occupancy-based issue stall.
module mul_wb_pipe #(
  parameter int LATENCY    = 2,
  parameter int SKID_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        opcode_valid_i,
  input  logic [31:0] opcode_opcode_i,
  input  logic [31:0] mul_value_i,
  input  logic        hold_i,
  input  logic        flush_i,
  input  logic        wb_ready_i,
  output logic        wb_valid_o,
  output logic [4:0]  wb_rd_idx_o,
  output logic [31:0] wb_value_o,
  output logic        stall_o,
  output logic        busy_o,
  output logic [31:0] pending_rd_mask_o
);

  localparam int PTR_W = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
  localparam int CNT_W = $clog2(SKID_DEPTH + 1);
  localparam int OCC_W = $clog2(LATENCY + SKID_DEPTH + 1);

  // Instruction decode: MUL/MULH/MULHSU/MULHU only (funct3[2]=0), never DIV/REM.
  logic [4:0] rd_in;
  logic       is_mul;
  logic       accept;
  logic       unused_opcode_bits;

  assign rd_in  = opcode_opcode_i[11:7];
  assign is_mul = (opcode_opcode_i[6:0] == 7'b0110011) &&
                  (opcode_opcode_i[31:25] == 7'b0000001) &&
                  !opcode_opcode_i[14];
  // rs1/rs2 and the low funct3 bits play no part in this stage.
  assign unused_opcode_bits = ^{opcode_opcode_i[24:15], opcode_opcode_i[13:12]};

  // Result pipeline
  logic [LATENCY-1:0] stage_valid_reg;
  logic [4:0]         stage_rd_reg    [LATENCY];
  logic [31:0]        stage_value_reg [LATENCY];

  // Skid FIFO
  logic [4:0]            fifo_rd_mem    [SKID_DEPTH];
  logic [31:0]           fifo_value_mem [SKID_DEPTH];
  logic [SKID_DEPTH-1:0] fifo_valid_reg;
  logic [PTR_W-1:0]      wr_ptr_reg;
  logic [PTR_W-1:0]      rd_ptr_reg;
  logic [CNT_W-1:0]      fifo_count_reg;

  logic             head_valid;
  logic             push;
  logic             pop;
  logic [OCC_W-1:0] stage_count;
  logic [OCC_W-1:0] occ;

  assign head_valid = (fifo_count_reg != '0);
  // The last stage only drains while the pipeline is not frozen; flush discards it.
  assign push       = stage_valid_reg[LATENCY-1] && !hold_i && !flush_i;
  assign pop        = head_valid && wb_ready_i;
  // Stall is derived from registered occupancy, so accept is too.
  assign accept     = opcode_valid_i && is_mul && (rd_in != 5'd0) &&
                      !hold_i && !stall_o && !flush_i;

  // Stage valids: cleared by reset/flush, shifted one stage per unheld cycle.
  always_ff @(posedge clk_i) begin
    if (!rst_i || flush_i) begin
      stage_valid_reg <= '0;
    end else if (!hold_i) begin
      stage_valid_reg[0] <= accept;
      for (int i = 1; i < LATENCY; i++) begin
        stage_valid_reg[i] <= stage_valid_reg[i-1];
      end
    end
  end

  // Stage payloads: value is sampled in the accept cycle; no reset needed.
  always_ff @(posedge clk_i) begin
    if (!hold_i) begin
      if (accept) begin
        stage_rd_reg[0]    <= rd_in;
        stage_value_reg[0] <= mul_value_i;
      end
      for (int i = 1; i < LATENCY; i++) begin
        stage_rd_reg[i]    <= stage_rd_reg[i-1];
        stage_value_reg[i] <= stage_value_reg[i-1];
      end
    end
  end

  // FIFO control: pointers, per-entry valids and count; pops ignore hold.
  always_ff @(posedge clk_i) begin
    if (!rst_i || flush_i) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      fifo_count_reg <= '0;
      fifo_valid_reg <= '0;
    end else begin
      // Occupancy limit means push and pop never target the same slot.
      if (push) begin
        wr_ptr_reg                 <= wr_ptr_reg + PTR_W'(1);
        fifo_valid_reg[wr_ptr_reg] <= 1'b1;
      end
      if (pop) begin
        rd_ptr_reg                 <= rd_ptr_reg + PTR_W'(1);
        fifo_valid_reg[rd_ptr_reg] <= 1'b0;
      end
      case ({push, pop})
        2'b10:   fifo_count_reg <= fifo_count_reg + CNT_W'(1);
        2'b01:   fifo_count_reg <= fifo_count_reg - CNT_W'(1);
        default: fifo_count_reg <= fifo_count_reg;
      endcase
    end
  end

  // FIFO storage write: payload of the last pipeline stage.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_rd_mem[wr_ptr_reg]    <= stage_rd_reg[LATENCY-1];
      fifo_value_mem[wr_ptr_reg] <= stage_value_reg[LATENCY-1];
    end
  end

  // Occupancy across pipeline and FIFO drives stall and busy.
  always_comb begin
    stage_count = '0;
    for (int i = 0; i < LATENCY; i++) begin
      stage_count = stage_count + OCC_W'(stage_valid_reg[i]);
    end
  end

  assign occ     = stage_count + OCC_W'(fifo_count_reg);
  assign stall_o = (occ >= OCC_W'(SKID_DEPTH));
  assign busy_o  = (occ != '0);

  // Head outputs are forced to zero when empty so stale storage never leaks.
  assign wb_valid_o  = head_valid;
  assign wb_rd_idx_o = head_valid ? fifo_rd_mem[rd_ptr_reg]    : 5'd0;
  assign wb_value_o  = head_valid ? fifo_value_mem[rd_ptr_reg] : 32'd0;

  // One-hot rd contribution of every stage and FIFO slot.
  logic [31:0] stage_onehot [LATENCY];
  logic [31:0] fifo_onehot  [SKID_DEPTH];

  generate
    for (genvar gi = 0; gi < LATENCY; gi++) begin : g_stage_mask
      assign stage_onehot[gi] = stage_valid_reg[gi] ? (32'd1 << stage_rd_reg[gi]) : 32'd0;
    end
    for (genvar gi = 0; gi < SKID_DEPTH; gi++) begin : g_fifo_mask
      assign fifo_onehot[gi] = fifo_valid_reg[gi] ? (32'd1 << fifo_rd_mem[gi]) : 32'd0;
    end
  endgenerate

  // Pending-rd mask: OR of all live entries; x0 is never a hazard.
  always_comb begin
    pending_rd_mask_o = 32'd0;
    for (int i = 0; i < LATENCY; i++) begin
      pending_rd_mask_o = pending_rd_mask_o | stage_onehot[i];
    end
    for (int i = 0; i < SKID_DEPTH; i++) begin
      pending_rd_mask_o = pending_rd_mask_o | fifo_onehot[i];
    end
    pending_rd_mask_o[0] = 1'b0;
  end

endmodule

// File: tb/tb_mul_wb_pipe.sv
// tb_mul_wb_pipe: directed scenarios followed by random traffic. A reference
// model tracks each accepted result as an entry with a countdown to FIFO
// arrival; accepted results also go to a scoreboard that a separate monitor
// drains whenever the DUT performs a writeback handshake.
module tb_mul_wb_pipe;

  localparam int LATENCY    = 2;
  localparam int SKID_DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        opcode_valid_i;
  logic [31:0] opcode_opcode_i;
  logic [31:0] mul_value_i;
  logic        hold_i;
  logic        flush_i;
  logic        wb_ready_i;
  logic        wb_valid_o;
  logic [4:0]  wb_rd_idx_o;
  logic [31:0] wb_value_o;
  logic        stall_o;
  logic        busy_o;
  logic [31:0] pending_rd_mask_o;

  mul_wb_pipe #(.LATENCY(LATENCY), .SKID_DEPTH(SKID_DEPTH)) dut (
    .clk_i             (clk),
    .rst_i             (rst_i),
    .opcode_valid_i    (opcode_valid_i),
    .opcode_opcode_i   (opcode_opcode_i),
    .mul_value_i       (mul_value_i),
    .hold_i            (hold_i),
    .flush_i           (flush_i),
    .wb_ready_i        (wb_ready_i),
    .wb_valid_o        (wb_valid_o),
    .wb_rd_idx_o       (wb_rd_idx_o),
    .wb_value_o        (wb_value_o),
    .stall_o           (stall_o),
    .busy_o            (busy_o),
    .pending_rd_mask_o (pending_rd_mask_o)
  );

  always #5 clk = ~clk;

  // Model entry: cd = edges still needed before the result reaches the FIFO.
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] value;
    int          cd;
  } ent_t;

  ent_t        model_q[$];
  logic [36:0] sb_q[$];
  int          vectors     = 0;
  int          miscompares = 0;
  bit          after_reset = 1'b1;

  function automatic bit is_mul_op(input logic [31:0] op);
    return (op[6:0] == 7'b0110011) && (op[31:25] == 7'b0000001) && (op[14] == 1'b0);
  endfunction

  function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, 5'd3, 5'd4, f3, rd, 7'b0110011};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare registered-state outputs against the model's current state.
  task automatic check_state();
    logic [31:0] m;
    m = 32'd0;
    foreach (model_q[i]) m = m | (32'd1 << model_q[i].rd);
    chk("stall", 32'(stall_o), 32'(model_q.size() >= SKID_DEPTH));
    chk("busy", 32'(busy_o), 32'(model_q.size() != 0));
    chk("wb_valid", 32'(wb_valid_o), 32'(model_q.size() != 0 && model_q[0].cd == 0));
    chk("mask", pending_rd_mask_o, m);
    chk("fifo_bound", 32'(dut.fifo_count_reg <= SKID_DEPTH), 32'd1);
    if (after_reset) begin
      chk("rst_rd", 32'(wb_rd_idx_o), 32'd0);
      chk("rst_value", wb_value_o, 32'd0);
    end
  endtask

  // One clock of stimulus: check, drive, then advance the model.
  task automatic step(input bit v, input logic [31:0] op, input logic [31:0] val,
                      input bit h, input bit f, input bit r, input bit rs);
    bit   acc;
    ent_t e;
    @(negedge clk);
    check_state();
    after_reset     = 1'b0;
    opcode_valid_i  = v;
    opcode_opcode_i = op;
    mul_value_i     = val;
    hold_i          = h;
    flush_i         = f;
    wb_ready_i      = r;
    rst_i           = rs;
    $display("cyc t=%0t v=%0b op=%08h val=%08h hold=%0b flush=%0b ready=%0b rst=%0b",
             $time, v, op, val, h, f, r, rs);
    if (!rs || f) begin
      model_q.delete();
      sb_q.delete();
      after_reset = !rs;
    end else begin
      acc = v && is_mul_op(op) && (op[11:7] != 5'd0) && !h && (model_q.size() < SKID_DEPTH);
      if (model_q.size() != 0 && model_q[0].cd == 0 && r) void'(model_q.pop_front());
      if (!h) foreach (model_q[i]) if (model_q[i].cd > 0) model_q[i].cd = model_q[i].cd - 1;
      if (acc) begin
        e.rd    = op[11:7];
        e.value = val;
        e.cd    = LATENCY;
        model_q.push_back(e);
        sb_q.push_back({op[11:7], val});
      end
    end
  endtask

  task automatic idle(input int n, input bit r);
    for (int i = 0; i < n; i++) step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, r, 1'b1);
  endtask

  // Monitor: pops the scoreboard on every real writeback handshake.
  initial begin
    logic [36:0] exp;
    forever begin
      @(negedge clk);
      #2;
      if (rst_i && !flush_i && wb_valid_o && wb_ready_i) begin
        if (sb_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL wb_unexpected: got rd=%0d value=0x%08h, expected no writeback",
                   wb_rd_idx_o, wb_value_o);
        end else begin
          exp = sb_q.pop_front();
          chk("wb_rd", 32'(wb_rd_idx_o), 32'(exp[36:32]));
          chk("wb_value", wb_value_o, exp[31:0]);
        end
      end
    end
  end

  initial begin
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [31:0] op;
    rst_i = 1'b0; opcode_valid_i = 1'b0; opcode_opcode_i = '0; mul_value_i = '0;
    hold_i = 1'b0; flush_i = 1'b0; wb_ready_i = 1'b0;
    repeat (2) @(posedge clk);

    // Single MUL x5 = 42 with ready writeback
    step(1, rtype(7'd1, 3'd0, 5'd5), 32'd42, 0, 0, 1, 1);
    idle(5, 1);

    // Backpressure: four MULs fill the occupancy budget, fifth is ignored
    for (int i = 1; i <= 4; i++) step(1, rtype(7'd1, 3'd0, 5'(i)), 32'(i), 0, 0, 0, 1);
    repeat (3) step(1, rtype(7'd1, 3'd0, 5'd6), 32'd99, 0, 0, 0, 1);
    idle(8, 1);

    // Hold for three cycles delays the result by three cycles
    step(1, rtype(7'd1, 3'd0, 5'd9), 32'h1234_5678, 0, 0, 1, 1);
    repeat (3) step(0, 32'd0, 32'd0, 1, 0, 1, 1);
    idle(6, 1);

    // Flush with one FIFO entry and two in flight; MUL in flush cycle is dropped
    step(1, rtype(7'd1, 3'd0, 5'd10), 32'hA, 0, 0, 0, 1);
    idle(LATENCY + 1, 0);
    step(1, rtype(7'd1, 3'd0, 5'd11), 32'hB, 0, 0, 0, 1);
    step(1, rtype(7'd1, 3'd0, 5'd12), 32'hC, 0, 0, 0, 1);
    step(1, rtype(7'd1, 3'd0, 5'd13), 32'hD, 0, 1, 1, 1);
    idle(6, 1);

    // Non-entries: DIV, MULHU to x0, ADD; then MULHU to x31
    step(1, rtype(7'd1, 3'd4, 5'd7), 32'd1, 0, 0, 1, 1);
    step(1, rtype(7'd1, 3'd3, 5'd0), 32'd2, 0, 0, 1, 1);
    step(1, rtype(7'd0, 3'd0, 5'd8), 32'd3, 0, 0, 1, 1);
    idle(4, 1);
    step(1, rtype(7'd1, 3'd3, 5'd31), 32'hFFFF_0001, 0, 0, 1, 1);
    idle(5, 1);

    // Reset mid-operation with three entries in flight, then a clean MUL
    for (int i = 1; i <= 3; i++) step(1, rtype(7'd1, 3'd0, 5'(i)), 32'(100 + i), 0, 0, 0, 1);
    step(0, 32'd0, 32'd0, 0, 0, 0, 0);
    step(1, rtype(7'd1, 3'd0, 5'd5), 32'd42, 0, 0, 1, 1);
    idle(5, 1);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      f7 = ($urandom_range(0, 9) == 0) ? 7'($urandom) : 7'd1;
      f3 = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      op = rtype(f7, f3, 5'($urandom));
      if ($urandom_range(0, 19) == 0) op = $urandom;
      step($urandom_range(0, 9) < 7, op, $urandom, $urandom_range(0, 9) == 0,
           $urandom_range(0, 49) == 0, $urandom_range(0, 9) < 6,
           $urandom_range(0, 199) != 0);
    end

    idle(LATENCY + SKID_DEPTH + 4, 1);
    #5;
    chk("drain", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
